muu_ht_read_nway: RTL



---
 rtl/muu_ht_pkg.sv | 35 +++
 rtl/muu_rr_arbiter.sv | 30 +++
 rtl/muu_ht_read_nway.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muu_ht_pkg.sv
// Shared types and field-offset helpers for the MUU hash-table read issuer.
package muu_ht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_OUTPUT = 2'd2
  } ht_state_e;

  localparam int DEF_KEY_WIDTH  = 128;
  localparam int DEF_META_WIDTH = 96;
  localparam int DEF_USER_BITS  = 3;

  // Opcodes 0 and 7 go straight to the compare stage without bucket reads.
  localparam logic [15:0] DEF_SKIP_OPCODE_MASK = 16'h0081;

  // Field offsets inside a request word {hash, user, key/meta} for the default widths.
  localparam int USER_LSB = DEF_KEY_WIDTH + DEF_META_WIDTH;
  localparam int HASH_LSB = USER_LSB + DEF_USER_BITS;
  localparam int OPC_LSB  = DEF_KEY_WIDTH + DEF_META_WIDTH - 8;

  // Same offsets for arbitrary widths, used by parametrised instances.
  function automatic int user_lsb(input int key_w, input int meta_w);
    return key_w + meta_w;
  endfunction

  function automatic int hash_lsb(input int key_w, input int meta_w, input int user_w);
    return key_w + meta_w + user_w;
  endfunction

  function automatic int opc_lsb(input int key_w, input int meta_w);
    return key_w + meta_w - 8;
  endfunction

endpackage

// File: rtl/muu_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module muu_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  // Walk offsets 1..N from last_grant; the first requesting channel wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && (j == ((int'(last_grant) + i) % N)) && req[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/muu_ht_read_nway.sv
// Hash-table read issuer: arbitrates request channels, issues NUM_WAYS bucket
// reads per request, then forwards the request word to the compare stage.
module muu_ht_read_nway
  import muu_ht_pkg::*;
#(
  parameter int          KEY_WIDTH        = DEF_KEY_WIDTH,
  parameter int          META_WIDTH       = DEF_META_WIDTH,
  parameter int          HASHADDR_WIDTH   = 64,
  parameter int          MEMADDR_WIDTH    = 21,
  parameter int          USER_BITS        = DEF_USER_BITS,
  parameter int          NUM_CH           = 2,
  parameter int          NUM_WAYS         = 2,
  parameter logic [15:0] SKIP_OPCODE_MASK = DEF_SKIP_OPCODE_MASK,
  parameter int          RDCMD_WIDTH      = 32,
  localparam int         W                = KEY_WIDTH + META_WIDTH + USER_BITS + HASHADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*W-1:0]    in_data,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  output logic [W-1:0]           output_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RDCMD_WIDTH-1:0] rdcmd_data,
  output logic                   rdcmd_valid,
  input  logic                   rdcmd_ready,
  output logic [31:0]            req_count
);

  localparam int USER_OFS = user_lsb(KEY_WIDTH, META_WIDTH);
  localparam int HASH_OFS = hash_lsb(KEY_WIDTH, META_WIDTH, USER_BITS);
  localparam int OPC_OFS  = opc_lsb(KEY_WIDTH, META_WIDTH);
  localparam int SLICE_W  = HASHADDR_WIDTH / NUM_WAYS;
  localparam int LOW_W    = MEMADDR_WIDTH - USER_BITS;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int K_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  ht_state_e           state_q, state_d;
  logic [W-1:0]        hold_q;
  logic [CH_W-1:0]     last_grant;
  logic [K_W-1:0]      k;
  logic [NUM_CH-1:0]   arb_req;
  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic [W-1:0]        sel_data;
  logic                skip;
  logic                take;
  logic                last_way;
  logic [LOW_W-1:0]    rd_low;
  logic [MEMADDR_WIDTH-1:0] rd_addr;

  // A new request may only be granted while nothing is being issued or forwarded.
  assign arb_req = in_valid & {NUM_CH{!output_valid && !rdcmd_valid}};

  muu_rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Pick the granted channel's word; non-granted channels are never looked at.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) sel_data = in_data[c*W +: W];
    end
  end

  assign skip     = SKIP_OPCODE_MASK[sel_data[OPC_OFS +: 4]];
  assign last_way = (k == K_W'(NUM_WAYS - 1));

  // Select the low address bits of the current way's hash slice.
  always_comb begin
    rd_low = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (k == K_W'(w)) rd_low = hold_q[HASH_OFS + w*SLICE_W +: LOW_W];
    end
  end

  assign rd_addr      = {hold_q[USER_OFS +: USER_BITS], rd_low};
  assign rdcmd_valid  = (state_q == ST_ISSUE);
  assign rdcmd_data   = rdcmd_valid ? RDCMD_WIDTH'(rd_addr) : '0;
  assign output_valid = (state_q == ST_OUTPUT);
  assign output_data  = hold_q;

  // Next-state logic and the one-cycle acceptance pulse.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    in_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          take     = 1'b1;
          in_ready = grant;
          state_d  = skip ? ST_OUTPUT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rdcmd_ready && last_way) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (output_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request, arbitration pointer, way counter and request count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      k          <= '0;
      req_count  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        hold_q     <= sel_data;
        last_grant <= grant_idx;
        req_count  <= req_count + 32'd1;
        k          <= '0;
      end else if (rdcmd_valid && rdcmd_ready) begin
        k <= k + 1'b1;
      end
    end
  end

endmodule
